// File: rtl/adder_rr_scheduler_if.sv
// Requester and result channel bundle for the shared-adder scheduler.
// The master side is the client/sink population; the slave side is the scheduler.
interface adder_rr_scheduler_if #(
  parameter int unsigned N = 16,
  parameter int unsigned R = 4
);
  localparam int unsigned IDW = $clog2(R);

  logic [R-1:0]   req_valid;
  logic [R-1:0]   req_ready;
  logic [R*N-1:0] req_a;
  logic [R*N-1:0] req_b;
  logic           res_valid;
  logic           res_ready;
  logic [N-1:0]   res_sum;
  logic           res_cout;
  logic [IDW-1:0] res_id;
  logic [15:0]    busy_cnt;

  modport master (
    output req_valid, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_sum, res_cout, res_id, busy_cnt
  );

  modport slave (
    input  req_valid, req_a, req_b, res_ready,
    output req_ready, res_valid, res_sum, res_cout, res_id, busy_cnt
  );
endinterface

// File: rtl/adder_rr_scheduler.sv
// Round-robin scheduler sharing one Kogge-Stone adder among R requesters,
// with a one-deep registered result stage on a valid/ready channel.
module adder_rr_scheduler #(
  parameter int unsigned N = 16,
  parameter int unsigned R = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  adder_rr_scheduler_if.slave  bus
);
  localparam int unsigned IDW = $clog2(R);
  localparam int unsigned CW  = 16;
  localparam int unsigned LVL = $clog2(N);

  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] r_id;
  logic [N-1:0]   r_sum;
  logic           r_cout;
  logic [CW-1:0]  r_busy;

  logic [IDW-1:0] w_scan;
  logic [IDW-1:0] w_gnt_idx;
  logic [IDW-1:0] w_sel;
  logic [IDW-1:0] w_ptr_nxt;
  logic           w_found;
  logic           w_accept_en;
  logic           w_fire;
  logic [N-1:0]   w_req_a [R];
  logic [N-1:0]   w_req_b [R];
  logic [N-1:0]   w_op_a;
  logic [N-1:0]   w_op_b;
  logic [N-1:0]   w_sum;
  logic           w_cout;
  logic [N-1:0]   w_g [LVL+1];
  logic [N-1:0]   w_p [LVL];

  for (genvar g = 0; g < R; g++) begin : g_unpack
    assign w_req_a[g] = bus.req_a[g*N +: N];
    assign w_req_b[g] = bus.req_b[g*N +: N];
  end

  assign w_accept_en = (r_state == ST_EMPTY) | bus.res_ready;

  // Circular search for the first valid requester starting at r_ptr.
  always_comb begin : arb
    w_found   = 1'b0;
    w_gnt_idx = r_ptr;
    w_scan    = r_ptr;
    for (int k = 0; k < int'(R); k++) begin
      w_scan = IDW'((int'(r_ptr) + k) % int'(R));
      if (!w_found && bus.req_valid[w_scan]) begin
        w_found   = 1'b1;
        w_gnt_idx = w_scan;
      end
    end
  end

  assign w_fire        = w_found & w_accept_en;
  assign bus.req_ready = (rst_n && w_fire) ? (R'(1) << w_gnt_idx) : '0;
  assign w_sel         = w_found ? w_gnt_idx : r_ptr;
  assign w_op_a        = w_req_a[w_sel];
  assign w_op_b        = w_req_b[w_sel];
  assign w_ptr_nxt     = (w_gnt_idx == IDW'(R - 1)) ? '0 : w_gnt_idx + 1'b1;

  // Kogge-Stone prefix adder: log2(N) generate/propagate combine levels.
  assign w_g[0] = w_op_a & w_op_b;
  assign w_p[0] = w_op_a ^ w_op_b;
  for (genvar s = 0; s < LVL; s++) begin : g_ks
    assign w_g[s+1] = w_g[s] | (w_p[s] & (w_g[s] << (1 << s)));
    if (s + 1 < LVL) begin : g_prop
      assign w_p[s+1] = w_p[s] & (w_p[s] << (1 << s));
    end
  end
  assign w_sum  = w_p[0] ^ {w_g[LVL][N-2:0], 1'b0};
  assign w_cout = w_g[LVL][N-1];

  always_comb begin : fsm_nxt
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: if (w_fire) w_state_nxt = ST_FULL;
      ST_FULL: begin
        if (w_fire)             w_state_nxt = ST_FULL;
        else if (bus.res_ready) w_state_nxt = ST_EMPTY;
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin : regs
    if (!rst_n) begin
      r_state <= ST_EMPTY;
      r_ptr   <= '0;
      r_id    <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_busy  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_fire) begin
        r_sum  <= w_sum;
        r_cout <= w_cout;
        r_id   <= w_gnt_idx;
        r_ptr  <= w_ptr_nxt;
      end
      // Stall monitor saturates rather than wrapping.
      if ((r_state == ST_FULL) && !bus.res_ready && (r_busy != '1)) begin
        r_busy <= r_busy + 1'b1;
      end
    end
  end

  assign bus.res_valid = (r_state == ST_FULL);
  assign bus.res_sum   = r_sum;
  assign bus.res_cout  = r_cout;
  assign bus.res_id    = r_id;
  assign bus.busy_cnt  = r_busy;
endmodule
